// File: rtl/sag_serial.sv
`default_nettype none
// ============================================================================
// Module      : sag_serial
// Description : Bit-serial SAG / NRSAG unit, one control bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sag_serial (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_di,
  input  logic [7:0] in_ci,
  input  logic       in_mode,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_do
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_PASS1 = 2'd1;
  localparam logic [1:0] c_PASS2 = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0] r_state;
  logic [2:0] r_bitCnt;
  logic [2:0] r_jPtr;
  logic [2:0] r_kPtr;
  logic [7:0] r_data;
  logic [7:0] r_ctrl;
  logic       r_mode;
  logic [7:0] r_res;
  logic [3:0] r_popCnt;

  logic       w_bit;
  logic       w_sel;
  logic       w_last;
  logic [7:0] w_resNext;
  logic [3:0] w_popNext;
  logic [7:0] w_mask;

  assign w_bit     = r_data[r_bitCnt];
  assign w_sel     = r_ctrl[r_bitCnt];
  assign w_last    = (r_bitCnt == 3'd7);
  assign w_popNext = r_popCnt + {3'b000, w_sel};
  // Second-pass control word: the low popcount(ci) bits set (0..8 ones).
  assign w_mask    = ~(8'hFF << w_popNext);

  always_comb begin
    w_resNext = r_res;
    if (w_sel) begin
      w_resNext[r_jPtr] = w_bit;
    end else begin
      w_resNext[r_kPtr] = w_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= c_IDLE;
      r_bitCnt <= 3'd0;
      r_jPtr   <= 3'd0;
      r_kPtr   <= 3'd0;
      r_data   <= 8'h00;
      r_ctrl   <= 8'h00;
      r_mode   <= 1'b0;
      r_res    <= 8'h00;
      r_popCnt <= 4'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (in_valid) begin
            r_data   <= in_di;
            r_ctrl   <= in_ci;
            r_mode   <= in_mode;
            r_bitCnt <= 3'd0;
            r_jPtr   <= 3'd0;
            r_kPtr   <= 3'd7;
            r_res    <= 8'h00;
            r_popCnt <= 4'd0;
            r_state  <= c_PASS1;
          end
        end
        c_PASS1, c_PASS2: begin
          r_res    <= w_resNext;
          r_popCnt <= w_popNext;
          r_bitCnt <= r_bitCnt + 3'd1;
          if (!w_last) begin
            if (w_sel) begin
              r_jPtr <= r_jPtr + 3'd1;
            end else begin
              r_kPtr <= r_kPtr - 3'd1;
            end
          end else if ((r_state == c_PASS1) && r_mode) begin
            // Re-run the same engine on the first-pass result.
            r_data  <= w_resNext;
            r_ctrl  <= w_mask;
            r_res   <= 8'h00;
            r_jPtr  <= 3'd0;
            r_kPtr  <= 3'd7;
            r_state <= c_PASS2;
          end else begin
            r_state <= c_DONE;
          end
        end
        c_DONE: begin
          if (out_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == c_IDLE);
  assign out_valid = (r_state == c_DONE);
  assign out_do    = (r_state == c_DONE) ? r_res : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_sag_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_sag_serial
// Description : Self-checking bench for sag_serial (vectors + scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sag_serial;

  logic       clk = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_di;
  logic [7:0] in_ci;
  logic       in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_do;

  sag_serial dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_di     (in_di),
    .in_ci     (in_ci),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_do    (out_do)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] exp;
    logic       mode;
    int         acc;
  } sb_t;

  typedef struct {
    logic [7:0] di;
    logic [7:0] ci;
    logic       mode;
    logic [7:0] exp;
  } vec_t;

  sb_t  sbQ[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   lastAcc = 0;
  int   zeroViol = 0;
  int   overlapViol = 0;
  logic prevValid = 1'b0;
  logic rdyRand = 1'b0;
  logic rdyForce = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic failNow(input string nm);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  function automatic logic [7:0] sagF(input logic [7:0] d, input logic [7:0] c);
    logic [7:0] r;
    int j, k;
    r = 8'h00; j = 0; k = 7;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) begin r[j] = d[i]; j++; end
      else      begin r[k] = d[i]; k--; end
    end
    return r;
  endfunction

  function automatic logic [7:0] modelF(input logic [7:0] d, input logic [7:0] c, input logic m);
    if (!m) return sagF(d, c);
    return sagF(sagF(d, c), sagF(c, c));
  endfunction

  // Output side: latency on the rising edge of out_valid, data on handshake.
  always @(negedge clk) begin
    if (resetn) begin
      if (out_valid && !prevValid) begin
        if (sbQ.size() == 0) failNow("spurious_out_valid");
        else chk("latency", 32'(cyc - sbQ[0].acc), sbQ[0].mode ? 32'd16 : 32'd8);
      end
      if (out_valid && out_ready) begin
        if (sbQ.size() == 0) failNow("unexpected_handshake");
        else begin
          sb_t e;
          e = sbQ.pop_front();
          chk("out_do", {24'h0, out_do}, {24'h0, e.exp});
        end
      end
      if (!out_valid && out_do != 8'h00) zeroViol++;
      if (in_ready && out_valid) overlapViol++;
    end
    prevValid = out_valid;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdyRand ? ($urandom_range(0, 1) == 1) : rdyForce;
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic doOp(input logic [7:0] d, input logic [7:0] c, input logic m, input logic [7:0] exp);
    int w;
    in_di = d; in_ci = c; in_mode = m; in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      failNow("accept_timeout");
    end else begin
      lastAcc = cyc + 1;
      sbQ.push_back('{exp: exp, mode: m, acc: cyc + 1});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_di = 8'($urandom); in_ci = 8'($urandom); in_mode = 1'($urandom);
  endtask

  task automatic waitDrain();
    int w;
    w = 0;
    while (sbQ.size() != 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (sbQ.size() != 0) begin
      failNow("drain_timeout");
      sbQ.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl[10];
    int a0, w;
    logic [7:0] d;

    tbl[0] = '{di: 8'hB2, ci: 8'h0F, mode: 1'b0, exp: 8'hD2};
    tbl[1] = '{di: 8'hB2, ci: 8'h0F, mode: 1'b1, exp: 8'hB2};
    tbl[2] = '{di: 8'h01, ci: 8'h00, mode: 1'b0, exp: 8'h80};
    tbl[3] = '{di: 8'h01, ci: 8'h00, mode: 1'b1, exp: 8'h01};
    tbl[4] = '{di: 8'h5A, ci: 8'hFF, mode: 1'b0, exp: 8'h5A};
    tbl[5] = '{di: 8'h5A, ci: 8'h7F, mode: 1'b0, exp: 8'h5A};
    tbl[6] = '{di: 8'h5A, ci: 8'hFF, mode: 1'b1, exp: 8'h5A};
    tbl[7] = '{di: 8'h35, ci: 8'h00, mode: 1'b0, exp: 8'hAC};
    tbl[8] = '{di: 8'hF0, ci: 8'hAA, mode: 1'b0, exp: 8'h3C};
    tbl[9] = '{di: 8'hF0, ci: 8'h2A, mode: 1'b0, exp: 8'h3C};

    resetn = 1'b0; in_valid = 1'b0; in_di = 8'h00; in_ci = 8'h00; in_mode = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", {31'h0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'h0, out_valid}, 32'd0);
    chk("reset_out_do", {24'h0, out_do}, 32'd0);

    rdyForce = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      doOp(tbl[i].di, tbl[i].ci, tbl[i].mode, tbl[i].exp);
      waitDrain();
    end

    // Back-to-back throughput with in_valid held and out_ready=1.
    doOp(8'h12, 8'h34, 1'b0, modelF(8'h12, 8'h34, 1'b0));
    a0 = lastAcc;
    doOp(8'h56, 8'h78, 1'b0, modelF(8'h56, 8'h78, 1'b0));
    chk("throughput_sag", 32'(lastAcc - a0), 32'd10);
    doOp(8'h9A, 8'hBC, 1'b1, modelF(8'h9A, 8'hBC, 1'b1));
    a0 = lastAcc;
    doOp(8'hDE, 8'hF1, 1'b1, modelF(8'hDE, 8'hF1, 1'b1));
    chk("throughput_nrsag", 32'(lastAcc - a0), 32'd18);
    waitDrain();

    // Backpressure in DONE.
    rdyForce = 1'b0;
    @(posedge clk);
    #1;
    doOp(8'hB2, 8'h0F, 1'b0, 8'hD2);
    w = 0;
    while (!out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!out_valid) failNow("bp_valid_timeout");
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", {31'h0, out_valid}, 32'd1);
      chk("bp_out_do", {24'h0, out_do}, 32'hD2);
      chk("bp_in_ready", {31'h0, in_ready}, 32'd0);
      @(negedge clk);
    end
    rdyForce = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", {31'h0, in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'h0, out_valid}, 32'd0);
    waitDrain();

    // Reset in the middle of PASS2 aborts the operation.
    doOp(8'hB2, 8'h0F, 1'b1, 8'hB2);
    repeat (10) @(posedge clk);
    #1;
    resetn = 1'b0;
    sbQ.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", {31'h0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("midrst_out_do", {24'h0, out_do}, 32'd0);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1;
    doOp(8'hB2, 8'h0F, 1'b0, 8'hD2);
    waitDrain();

    // Accept request coinciding with reset is ignored.
    in_valid = 1'b1; in_di = 8'hA5; in_ci = 8'h3C; in_mode = 1'b1; resetn = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0; resetn = 1'b1;
    @(negedge clk);
    chk("rst_accept_ignored", {31'h0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Randomised sweep of all control words in both modes against the model.
    rdyRand = 1'b1;
    for (int i = 0; i < 512; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      d = 8'($urandom);
      doOp(d, 8'(i), i[8], modelF(d, 8'(i), i[8]));
    end
    waitDrain();
    rdyRand = 1'b0;

    chk("out_do_zero_outside_done", 32'(zeroViol), 32'd0);
    chk("no_handshake_overlap", 32'(overlapViol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sag_serial.md
SAG_SERIAL -- requirements
Module: sag_serial

Interface
REQ-001 Parameters: none; data width fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  operand available.
REQ-005 in_ready  output  1  block can accept an operand.
REQ-006 in_di  input  8  data word.
REQ-007 in_ci  input  8  control word.
REQ-008 in_mode  input  1  0 = SAG, 1 = NRSAG.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_do  output  8  result word.

Function
REQ-012 SAG(d,c) SHALL be defined as follows, with j=0 and k=7 initially, for i=0..7 in order:
- if c[i]=1: r[j]=d[i], then j=j+1;
- else: r[k]=d[i], then k=k-1.
REQ-013 NRSAG(d,c) SHALL equal SAG(SAG(d,c), m), where m=SAG(c,c), i.e. the low popcount(c) bits set.
REQ-014 FSM states SHALL be IDLE, PASS1, PASS2, DONE.
REQ-015 Input handshake: in_ready=1 only in IDLE; accept on an edge with in_valid&&in_ready; capture in_di, in_ci, in_mode; IDLE->PASS1.
REQ-016 PASS1 SHALL process exactly one bit per cycle, i=0..7, using a 3-bit bit counter and 3-bit j/k write pointers.
REQ-017 PASS1 SHALL count popcount(ci) concurrently.
REQ-018 At PASS1 end: mode 0 -> DONE; mode 1 -> PASS2 with d = PASS1 result and control = m.
REQ-019 PASS2 SHALL process one bit per cycle, i=0..7, with the same rule, then -> DONE.
REQ-020 Latency: out_valid SHALL rise 8 edges after the accept edge for SAG and 16 for NRSAG.
REQ-021 DONE: out_valid=1; out_do holds the result, stable while out_ready=0.
REQ-022 On an edge with out_valid&&out_ready: DONE->IDLE, out_valid=0.
REQ-023 Accept and output handshakes SHALL never coincide; throughput is 1 op per 10 (SAG) or 18 (NRSAG) cycles, given out_ready=1 and in_valid=1.
REQ-024 Bit 7 of any control word SHALL NOT change the result; at i=7, j==k always holds.
REQ-025 ci=8'h00 SHALL bit-reverse d; ci=8'hFF SHALL pass d unchanged; pointers never wrap.
REQ-026 in_di/in_ci/in_mode changes while not in IDLE SHALL have no effect.
REQ-027 out_do SHALL be 8'h00 in every state except DONE.

Reset
REQ-028 resetn=0 at an edge SHALL force IDLE, clear counters, pointers and data registers.
REQ-029 Reset values: in_ready=1 and out_valid=0 on the cycle after the reset edge; out_do=8'h00.
REQ-030 Reset mid-PASS1/PASS2/DONE SHALL abort the operation; no out_valid pulse results from it.
REQ-031 An accept requested in the same cycle as resetn=0 SHALL be ignored.

Verification
REQ-032 SAG: di=8'hB2, ci=8'h0F, mode 0 -> out_do=8'hD2, out_valid exactly 8 cycles after accept.
REQ-033 NRSAG: di=8'hB2, ci=8'h0F, mode 1 -> out_do=8'hB2, out_valid 16 cycles after accept.
REQ-034 Edge controls:
- di=8'h01, ci=8'h00, mode 0 -> 8'h80;
- same with mode 1 -> 8'h01;
- di=8'h5A, ci=8'hFF or 8'h7F, mode 0 -> 8'h5A.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_do stable, in_ready=0; release -> IDLE next cycle.
REQ-036 Reset at PASS2 cycle 3 -> next cycle in_ready=1, out_valid=0; a new SAG op afterwards completes correctly.
REQ-037 Exhaustive: all 65536 {ci,di} pairs in both modes, random in_valid/out_ready gaps; compare against a SAG/NRSAG software model; zero mismatches.
